seq_detect: RTL and testbench

SEQ_DETECT -- requirements
Module: seq_detect

---
 rtl/seq_detect_pkg.sv | 14 +
 rtl/seq_detect_sat_cnt.sv | 24 ++
 rtl/seq_detect.sv | 89 ++++++++
 tb/tb_seq_detect.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding and
// default widths used by the top level.
package seq_detect_pkg;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_ARMED   = 2'd2
  } state_t;

endpackage

// File: rtl/seq_detect_sat_cnt.sv
// Saturating up-counter with a synchronous clear that takes priority over
// the increment.
module seq_detect_sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_detect.sv
// Serial pattern detector: shifts qualified bits into a history register and
// pulses detect when a full window equals the loaded pattern.
module seq_detect
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inbits,
  input  logic             in_valid,
  input  logic [PAT_W-1:0] pattern,
  input  logic             pattern_load,
  input  logic             overlap,
  input  logic             clear_count,
  output logic             detect,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  state_t            state;
  logic [PAT_W-1:0]  history;
  logic [PAT_W-1:0]  pattern_reg;
  logic [FILL_W-1:0] fill_cnt;

  logic              accept;
  logic              arming;
  logic              match;
  logic [PAT_W-1:0]  history_shift;
  logic [FILL_W-1:0] fill_inc;

  // A load cycle swallows any bit presented alongside it.
  always_comb begin
    accept        = in_valid && !pattern_load;
    history_shift = {history[PAT_W-2:0], inbits};
    fill_inc      = (fill_cnt == FILL_W'(PAT_W)) ? fill_cnt : fill_cnt + FILL_W'(1);
    arming        = (state == ST_ARMED) || (fill_inc == FILL_W'(PAT_W));
    match         = accept && arming && (history_shift == pattern_reg);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_EMPTY;
      history     <= '0;
      pattern_reg <= '0;
      fill_cnt    <= '0;
      detect      <= 1'b0;
      armed       <= 1'b0;
    end else begin
      detect <= match;
      if (pattern_load) begin
        pattern_reg <= pattern;
        fill_cnt    <= '0;
        state       <= ST_EMPTY;
        armed       <= 1'b0;
      end else if (accept) begin
        history <= history_shift;
        // Non-overlapping mode needs a whole fresh window after each hit.
        if (match && !overlap) begin
          fill_cnt <= '0;
          state    <= ST_EMPTY;
          armed    <= 1'b0;
        end else if (arming) begin
          fill_cnt <= fill_inc;
          state    <= ST_ARMED;
          armed    <= 1'b1;
        end else begin
          fill_cnt <= fill_inc;
          state    <= ST_FILLING;
          armed    <= 1'b0;
        end
      end
    end
  end

  seq_detect_sat_cnt #(
    .WIDTH(CNT_W)
  ) u_sat_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (clear_count),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detect.sv
// Directed bench for seq_detect: three instances (4-bit, 2-bit pattern, and a
// 2-bit counter) share one stimulus stream; each test checks the relevant one.
module tb_seq_detect;

  logic       clk = 1'b0;
  logic       reset;
  logic       inbits;
  logic       in_valid;
  logic       pattern_load;
  logic       overlap;
  logic       clear_count;
  logic [3:0] pat4;
  logic [1:0] pat2;

  logic       det4, det2, dets;
  logic [7:0] cnt4, cnt2;
  logic [1:0] cnts;
  logic       arm4, arm2, arms;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_detect #(.PAT_W(4), .CNT_W(8)) dut4 (
    .clk(clk), .reset(reset), .inbits(inbits), .in_valid(in_valid),
    .pattern(pat4), .pattern_load(pattern_load), .overlap(overlap),
    .clear_count(clear_count), .detect(det4), .match_count(cnt4), .armed(arm4)
  );

  seq_detect #(.PAT_W(2), .CNT_W(8)) dut2 (
    .clk(clk), .reset(reset), .inbits(inbits), .in_valid(in_valid),
    .pattern(pat2), .pattern_load(pattern_load), .overlap(overlap),
    .clear_count(clear_count), .detect(det2), .match_count(cnt2), .armed(arm2)
  );

  seq_detect #(.PAT_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .inbits(inbits), .in_valid(in_valid),
    .pattern(pat4), .pattern_load(pattern_load), .overlap(overlap),
    .clear_count(clear_count), .detect(dets), .match_count(cnts), .armed(arms)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, wanted %0d", tag, observed, expected);
    end
  endtask

  // Present one bit for one clock edge, then sample #1 after that edge.
  task automatic applyStimulus(input logic b, input logic v);
    inbits   = b;
    in_valid = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inbits   = 1'b0;
  endtask

  // The load cycle also carries a valid '1' that must be ignored.
  task automatic loadPattern(input logic [3:0] p4, input logic [1:0] p2);
    pat4         = p4;
    pat2         = p2;
    pattern_load = 1'b1;
    in_valid     = 1'b1;
    inbits       = 1'b1;
    @(posedge clk);
    #1;
    pattern_load = 1'b0;
    in_valid     = 1'b0;
    inbits       = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_det", det4, 0);
    checkOutput("rst_cnt", cnt4, 0);
    checkOutput("rst_arm", arm4, 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  // Bits are sent MSB first; exp_det/exp_arm hold the value expected after each bit.
  task automatic runStream(input string name, input logic [15:0] bits, input int n,
                           input logic [15:0] exp_det, input logic [15:0] exp_arm,
                           input int which, input logic gaps);
    logic d, a;
    for (int i = 0; i < n; i++) begin
      applyStimulus(bits[n-1-i], 1'b1);
      case (which)
        1:       begin d = det2; a = arm2; end
        2:       begin d = dets; a = arms; end
        default: begin d = det4; a = arm4; end
      endcase
      checkOutput($sformatf("%s_det_b%0d", name, i + 1), d, exp_det[n-1-i]);
      checkOutput($sformatf("%s_arm_b%0d", name, i + 1), a, exp_arm[n-1-i]);
      if (gaps) begin
        applyStimulus(~bits[n-1-i], 1'b0);
        checkOutput($sformatf("%s_gap_b%0d", name, i + 1), det4, 0);
      end
    end
  endtask

  initial begin
    reset        = 1'b0;
    inbits       = 1'b0;
    in_valid     = 1'b0;
    pattern_load = 1'b0;
    overlap      = 1'b0;
    clear_count  = 1'b0;
    pat4         = 4'b0;
    pat2         = 2'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("init_det", det4, 0);
    checkOutput("init_cnt", cnt4, 0);
    checkOutput("init_arm", arm4, 0);
    #1;
    reset = 1'b1;

    $display("[TB] overlapping 1011");
    overlap = 1'b1;
    loadPattern(4'b1011, 2'b10);
    checkOutput("ovl_arm_load", arm4, 0);
    runStream("ovl", 16'b1011011, 7, 16'b0001001, 16'b0001111, 0, 1'b0);
    checkOutput("ovl_cnt", cnt4, 2);
    loadPattern(4'b1011, 2'b10);
    checkOutput("reload_cnt", cnt4, 2);
    checkOutput("reload_arm", arm4, 0);

    $display("[TB] non-overlapping 1011");
    doReset();
    overlap = 1'b0;
    loadPattern(4'b1011, 2'b10);
    runStream("novl", 16'b1011011, 7, 16'b0001000, 16'b0000000, 0, 1'b0);
    checkOutput("novl_cnt", cnt4, 1);

    $display("[TB] two-bit pattern 10");
    doReset();
    overlap = 1'b1;
    loadPattern(4'b0000, 2'b10);
    runStream("p2", 16'b10101010, 8, 16'b01010101, 16'b01111111, 1, 1'b0);
    checkOutput("p2_cnt", cnt2, 4);

    $display("[TB] saturation and clear priority");
    doReset();
    overlap = 1'b1;
    loadPattern(4'b1111, 2'b11);
    runStream("sat", 16'hFF, 8, 16'b00011111, 16'b00011111, 2, 1'b0);
    checkOutput("sat_cnt", cnts, 3);
    clear_count = 1'b1;
    applyStimulus(1'b1, 1'b1);
    checkOutput("clr_det", dets, 1);
    checkOutput("clr_cnt", cnts, 0);
    clear_count = 1'b0;
    applyStimulus(1'b1, 1'b1);
    checkOutput("post_clr_cnt", cnts, 1);

    $display("[TB] reset mid-stream");
    doReset();
    overlap = 1'b1;
    loadPattern(4'b1011, 2'b10);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("mid_arm", arm4, 0);
    doReset();
    runStream("noload", 16'b1011, 4, 16'b0000, 16'b0001, 0, 1'b0);
    loadPattern(4'b1011, 2'b10);
    runStream("restart", 16'b1011, 4, 16'b0001, 16'b0001, 0, 1'b0);
    checkOutput("restart_cnt", cnt4, 1);
    doReset();
    runStream("zero", 16'b0000, 4, 16'b0001, 16'b0001, 0, 1'b0);

    $display("[TB] gapped stream");
    doReset();
    overlap = 1'b1;
    loadPattern(4'b1011, 2'b10);
    runStream("gap", 16'b1011011, 7, 16'b0001001, 16'b0001111, 0, 1'b1);
    checkOutput("gap_cnt", cnt4, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
